// File: rtl/request_unit_if.sv
// Request/response bundle between the request sequencer, the control unit and the memory ports.
interface request_unit_if #(
    parameter int CNT_W = 32
);
    logic             ihit;
    logic             dhit;
    logic             dren_in;
    logic             dwen_in;
    logic             halt_in;
    logic             imemREN;
    logic             dmemREN;
    logic             dmemWEN;
    logic             pcEN;
    logic             halt;
    logic             err_timeout;
    logic             err_rw;
    logic [CNT_W-1:0] retired;
    logic [CNT_W-1:0] stalls;

    // Sequencer side: issues memory requests, consumes hits and decode strobes.
    modport master (
        input  ihit, dhit, dren_in, dwen_in, halt_in,
        output imemREN, dmemREN, dmemWEN, pcEN, halt, err_timeout, err_rw, retired, stalls
    );

    // Environment side: memory and control unit.
    modport slave (
        output ihit, dhit, dren_in, dwen_in, halt_in,
        input  imemREN, dmemREN, dmemWEN, pcEN, halt, err_timeout, err_rw, retired, stalls
    );
endinterface

// File: rtl/request_unit.sv
// Memory request sequencer: fetch, optional single data access, halt latch, data-access
// watchdog, and retired/stall counters.
module request_unit #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 32
) (
    input logic            CLK,
    input logic            RST,
    request_unit_if.master bus
);
    // Watchdog is wide enough to hold TIMEOUT and saturates there.
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

    typedef enum logic [1:0] {StFetch, StData, StHalted} state_e;

    state_e           state_q, state_d;
    logic             rd_q, rd_d;
    logic             wr_q, wr_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             halt_q, halt_d;
    logic             err_to_q, err_to_d;
    logic             err_rw_q, err_rw_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [CNT_W-1:0] stalls_q, stalls_d;
    logic             pc_en;

    // Next-state, request latches, sticky flags, counters and the PC strobe.
    always_comb begin
        state_d   = state_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        wd_d      = wd_q;
        halt_d    = halt_q;
        err_to_d  = err_to_q;
        err_rw_d  = err_rw_q;
        retired_d = retired_q;
        stalls_d  = stalls_q;
        pc_en     = 1'b0;

        unique case (state_q)
            StFetch: begin
                if (bus.ihit) begin
                    if (bus.halt_in) begin
                        // Halt wins over any data request decoded with it.
                        state_d = StHalted;
                        halt_d  = 1'b1;
                    end else if (bus.dren_in || bus.dwen_in) begin
                        state_d = StData;
                        rd_d    = bus.dren_in & ~bus.dwen_in;
                        wr_d    = bus.dwen_in;
                        wd_d    = '0;
                        if (bus.dren_in && bus.dwen_in) begin
                            err_rw_d = 1'b1;
                        end
                    end else begin
                        pc_en = 1'b1;
                    end
                end
            end
            StData: begin
                if (bus.dhit) begin
                    pc_en   = 1'b1;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = StFetch;
                end else if (wd_q != WD_MAX) begin
                    wd_d = wd_q + 1'b1;
                    if (wd_d == WD_MAX) begin
                        err_to_d = 1'b1;
                    end
                end
            end
            StHalted: begin
                state_d = StHalted;
            end
            default: begin
                state_d = StFetch;
            end
        endcase

        // Counters freeze once halted.
        if (state_q != StHalted) begin
            if (pc_en) begin
                retired_d = retired_q + 1'b1;
            end else begin
                stalls_d = stalls_q + 1'b1;
            end
        end
    end

    // State and latch registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= StFetch;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            wd_q      <= '0;
            halt_q    <= 1'b0;
            err_to_q  <= 1'b0;
            err_rw_q  <= 1'b0;
            retired_q <= '0;
            stalls_q  <= '0;
        end else begin
            state_q   <= state_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            wd_q      <= wd_d;
            halt_q    <= halt_d;
            err_to_q  <= err_to_d;
            err_rw_q  <= err_rw_d;
            retired_q <= retired_d;
            stalls_q  <= stalls_d;
        end
    end

    // Memory enables come only from registered state; pcEN is the one combinational output.
    assign bus.imemREN     = (state_q == StFetch);
    assign bus.dmemREN     = (state_q == StData) & rd_q;
    assign bus.dmemWEN     = (state_q == StData) & wr_q;
    assign bus.pcEN        = pc_en;
    assign bus.halt        = halt_q;
    assign bus.err_timeout = err_to_q;
    assign bus.err_rw      = err_rw_q;
    assign bus.retired     = retired_q;
    assign bus.stalls      = stalls_q;
endmodule

// File: doc/request_unit.md
# request_unit

Memory request sequencer that sits between the control unit and the instruction/data memory ports of the single-cycle datapath. It takes the decoded request strobes (dren, dwen, halt) and turns them into a handshaked request sequence against a shared memory. Each instruction fetch is followed, when needed, by exactly one data access. The PC is enabled only when the current instruction has fully completed. It also latches halt, watches for hung data accesses, and counts retired instructions and stall cycles.

## Interface
- TIMEOUT, 64: cycles allowed in DATA without dhit before the timeout error flag sets.
- CNT_W, 32: width of the retired-instruction and stall counters.

- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous reset, active-high.
- ihit  in  1  instruction memory response valid.
- dhit  in  1  data memory response valid.
- dren_in  in  1  control unit data read request (load).
- dwen_in  in  1  control unit data write request (store).
- halt_in  in  1  control unit halt decode.
- imemREN  out  1  instruction read enable.
- dmemREN  out  1  data read enable.
- dmemWEN  out  1  data write enable.
- pcEN  out  1  single-cycle PC advance strobe.
- halt  out  1  sticky halted indication.
- err_timeout  out  1  sticky data-access timeout flag.
- err_rw  out  1  sticky flag: dren_in and dwen_in both high at fetch completion.
- retired  out  CNT_W  count of pcEN pulses.
- stalls  out  CNT_W  count of non-HALT cycles with pcEN=0.

## Operation
- States: FETCH, DATA, HALTED. Reset state is FETCH.
- FETCH: imemREN=1, dmemREN=dmemWEN=0.
  - ihit=0: stay in FETCH.
  - ihit=1 and halt_in=1: go to HALTED. No pcEN. Halt takes priority over dren_in/dwen_in.
  - ihit=1 and (dren_in|dwen_in): go to DATA. Latch rd_q=dren_in&~dwen_in and wr_q=dwen_in. No pcEN.
  - ihit=1 and both dren_in and dwen_in: write wins (wr_q=1, rd_q=0) and err_rw sets.
  - ihit=1 with no request: pcEN=1 this cycle, stay in FETCH.
- DATA: imemREN=0, dmemREN=rd_q, dmemWEN=wr_q. Enables are held steady until dhit.
  - dhit=1: pcEN=1 this cycle, clear rd_q/wr_q, return to FETCH.
  - Watchdog counter increments each DATA cycle without dhit. When the count reaches TIMEOUT, err_timeout sets and the state stays in DATA (still waiting). The counter clears on entering DATA.
  - ihit in DATA is ignored.
- HALTED: all enables 0, pcEN=0, halt=1. Leaves only on RST. All inputs ignored.
- Counters:
  - retired increments on every pcEN=1.
  - stalls increments every cycle state≠HALTED and pcEN=0.
  - Both wrap modulo 2^CNT_W and freeze in HALTED.
- Sticky flags (halt, err_timeout, err_rw) clear only on RST.

## Timing
- Outputs imemREN, dmemREN, dmemWEN and halt are decoded from registered state/latches only. They never depend combinationally on ihit/dhit.
- pcEN is combinational: (FETCH & ihit & ~halt_in & ~dren_in & ~dwen_in) | (DATA & dhit).
- Instruction with no data access and ihit in cycle N: pcEN high in cycle N; the next fetch starts in cycle N+1.
- Load/store with ihit in cycle N: dmemREN/dmemWEN high from cycle N+1 until the dhit cycle M inclusive; pcEN high in cycle M; imemREN high again in M+1.
- Minimum load/store latency is 2 cycles (dhit in N+1).
- Reset values: imemREN=1 (state FETCH), dmemREN=0, dmemWEN=0, pcEN=0 unless ihit is high, halt=0, err_timeout=0, err_rw=0, retired=0, stalls=0.
- RST mid-DATA: the next cycle is FETCH, enables drop, and the latched request is discarded. RST overrides a simultaneous dhit (no pcEN count).

## Test plan
- Reset, then ihit held high with no requests for 5 cycles:
  - pcEN high all 5 cycles, imemREN=1 throughout.
  - retired=5, stalls=0.
- Load: ihit with dren_in=1 in cycle 1, dhit in cycle 4:
  - dmemREN=1 in cycles 2–4, imemREN=0 in cycles 2–4, pcEN only in cycle 4.
  - retired=1, stalls=3.
- Store with dren_in=dwen_in=1 at ihit:
  - dmemWEN=1, dmemREN=0, err_rw=1 after the edge.
  - pcEN on dhit.
- Halt: ihit with halt_in=1 and dwen_in=1:
  - Enters HALTED; dmemWEN never asserts; halt=1 held for 20 cycles despite ihit/dhit toggling.
  - Counters frozen.
- Timeout with TIMEOUT=4: load issued, dhit withheld:
  - err_timeout=1 after 4 DATA cycles, dmemREN still 1.
  - dhit in cycle 10 then completes with a pcEN pulse.
- RST asserted during DATA coincident with dhit:
  - Next cycle is FETCH, dmemREN=0, retired unchanged at 0, all flags 0.
